// File: rtl/memory_arbiter_if.sv
// Bundle of the two core-side requester ports and the backing-memory port
// of the memory arbiter.
interface memory_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          ins_req;
    logic [AW-1:0] ins_addr;
    logic [DW-1:0] ins_dout;
    logic          ins_busy;

    logic          data_req;
    logic          data_write;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_din;
    logic [DW-1:0] data_dout;
    logic          data_busy;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    // Arbiter side
    modport slave (
        input  ins_req, ins_addr, data_req, data_write, data_addr, data_din, mem_dout,
        output ins_dout, ins_busy, data_dout, data_busy, mem_en, mem_we, mem_addr, mem_din
    );

    // Requester / memory-model side
    modport master (
        output ins_req, ins_addr, data_req, data_write, data_addr, data_din, mem_dout,
        input  ins_dout, ins_busy, data_dout, data_busy, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported memory between the
// instruction-fetch and data load/store requesters, with per-requester stall.
module memory_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input logic             clk,
    input logic             reset,
    memory_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(LATENCY + 1);

    typedef enum logic {StIdle, StAccess} state_e;
    typedef enum logic {GrantIns, GrantData} grant_e;

    state_e          state_q, state_d;
    grant_e          grant_q, grant_d;
    grant_e          last_grant_q, last_grant_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            write_q, write_d;

    logic complete;
    logic ins_done;
    logic data_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= GrantIns;
            last_grant_q <= GrantData;
            cnt_q        <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            write_q      <= write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        din_d        = din_q;
        write_d      = write_q;
        unique case (state_q)
            StIdle: begin
                if (bus.ins_req || bus.data_req) begin
                    // A tie goes to whoever was not served last
                    if (bus.ins_req && bus.data_req) begin
                        grant_d = (last_grant_q == GrantIns) ? GrantData : GrantIns;
                    end else if (bus.ins_req) begin
                        grant_d = GrantIns;
                    end else begin
                        grant_d = GrantData;
                    end
                    addr_d  = (grant_d == GrantIns) ? bus.ins_addr : bus.data_addr;
                    din_d   = bus.data_din;
                    write_d = (grant_d == GrantData) && bus.data_write;
                    cnt_d   = CntW'(LATENCY - 1);
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (complete) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    assign complete  = (state_q == StAccess) && (cnt_q == '0);
    assign ins_done  = complete && (grant_q == GrantIns);
    assign data_done = complete && (grant_q == GrantData);

    // Write strobe only in the last access cycle: exactly one per store
    assign bus.mem_en   = (state_q == StAccess);
    assign bus.mem_we   = complete && write_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;

    assign bus.ins_busy  = bus.ins_req && !ins_done;
    assign bus.ins_dout  = ins_done ? bus.mem_dout : '0;
    assign bus.data_busy = bus.data_req && !data_done;
    assign bus.data_dout = data_done ? bus.mem_dout : '0;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: three instances (LATENCY 2, 3, 1) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_memory_arbiter;
    localparam int unsigned LAT [3] = '{2, 3, 1};

    logic clk = 1'b0;
    logic reset;

    logic [2:0]  ins_req, data_req, data_write;
    logic [31:0] ins_addr [3];
    logic [31:0] data_addr [3];
    logic [31:0] data_din [3];
    logic [31:0] mem_dout [3];
    wire  [2:0]  ins_busy, data_busy, mem_en, mem_we;
    wire  [31:0] ins_dout [3];
    wire  [31:0] data_dout [3];
    wire  [31:0] mem_addr [3];
    wire  [31:0] mem_din [3];

    memory_arbiter_if #(.AW(32), .DW(32)) bus [3] ();

    for (genvar k = 0; k < 3; k++) begin : g_dut
        assign bus[k].ins_req    = ins_req[k];
        assign bus[k].ins_addr   = ins_addr[k];
        assign bus[k].data_req   = data_req[k];
        assign bus[k].data_write = data_write[k];
        assign bus[k].data_addr  = data_addr[k];
        assign bus[k].data_din   = data_din[k];
        assign bus[k].mem_dout   = mem_dout[k];
        assign ins_busy[k]       = bus[k].ins_busy;
        assign ins_dout[k]       = bus[k].ins_dout;
        assign data_busy[k]      = bus[k].data_busy;
        assign data_dout[k]      = bus[k].data_dout;
        assign mem_en[k]         = bus[k].mem_en;
        assign mem_we[k]         = bus[k].mem_we;
        assign mem_addr[k]       = bus[k].mem_addr;
        assign mem_din[k]        = bus[k].mem_din;

        memory_arbiter #(.LATENCY(LAT[k]), .AW(32), .DW(32)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[k])
        );
    end

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing memory: sparse store over addr[9:2] with full-address tag
    bit          mvld [3][256];
    logic [31:0] mtag [3][256];
    logic [31:0] mval [3][256];
    int          wcnt [3] = '{0, 0, 0};

    function automatic logic [31:0] rd(input int k, input logic [31:0] a);
        if (mvld[k][a[9:2]] && mtag[k][a[9:2]] == a) return mval[k][a[9:2]];
        if (a == 32'h1000_0010) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_en[k] && mem_we[k]) begin
                mvld[k][mem_addr[k][9:2]] <= 1'b1;
                mtag[k][mem_addr[k][9:2]] <= mem_addr[k];
                mval[k][mem_addr[k][9:2]] <= mem_din[k];
                wcnt[k]                   <= wcnt[k] + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 3; k++) mem_dout[k] = rd(k, mem_addr[k]);
        end
    end

    // Transaction model: who is served (-1 none, 0 ins, 1 data) and in which cycle it completes
    int          cyc = 0;
    int          who [3] = '{-1, -1, -1};
    int          lastw [3] = '{1, 1, 1};
    int          done_at [3];
    logic [31:0] job_addr [3];
    logic [31:0] job_din [3];
    bit          job_wr [3];

    function automatic int pick_of(input int k);
        if (ins_req[k] && data_req[k]) return 1 - lastw[k];
        return ins_req[k] ? 0 : 1;
    endfunction

    function automatic bit comp_of(input int k);
        return (who[k] >= 0) && (cyc == done_at[k]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                who[k]   <= -1;
                lastw[k] <= 1;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (who[k] >= 0) begin
                    if (cyc == done_at[k]) begin
                        lastw[k] <= who[k];
                        who[k]   <= -1;
                    end
                end else if (ins_req[k] || data_req[k]) begin
                    who[k]      <= pick_of(k);
                    done_at[k]  <= cyc + int'(LAT[k]);
                    job_addr[k] <= (pick_of(k) == 1) ? data_addr[k] : ins_addr[k];
                    job_din[k]  <= data_din[k];
                    job_wr[k]   <= (pick_of(k) == 1) && data_write[k];
                end
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d mem_en", k), 32'(mem_en[k]), 32'(who[k] >= 0));
            chk($sformatf("u%0d mem_we", k), 32'(mem_we[k]), 32'(comp_of(k) && job_wr[k]));
            chk($sformatf("u%0d ins_busy", k), 32'(ins_busy[k]),
                32'(ins_req[k] && !(comp_of(k) && who[k] == 0)));
            chk($sformatf("u%0d data_busy", k), 32'(data_busy[k]),
                32'(data_req[k] && !(comp_of(k) && who[k] == 1)));
            chk($sformatf("u%0d ins_dout", k), ins_dout[k],
                (comp_of(k) && who[k] == 0) ? rd(k, job_addr[k]) : 32'h0);
            chk($sformatf("u%0d data_dout", k), data_dout[k],
                (comp_of(k) && who[k] == 1) ? rd(k, job_addr[k]) : 32'h0);
            if (who[k] >= 0) chk($sformatf("u%0d mem_addr", k), mem_addr[k], job_addr[k]);
            if (comp_of(k) && job_wr[k]) chk($sformatf("u%0d mem_din", k), mem_din[k], job_din[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int w0;
    int got;
    int prev;

    initial begin
        reset      = 1'b1;
        ins_req    = '0;
        data_req   = '0;
        data_write = '0;
        for (int k = 0; k < 3; k++) begin
            ins_addr[k]  = '0;
            data_addr[k] = '0;
            data_din[k]  = '0;
        end
        data_req[2] = 1'b1;
        sample();
        for (int k = 0; k < 3; k++) begin
            chk("reset mem_addr", mem_addr[k], 32'h0);
            chk("reset mem_din", mem_din[k], 32'h0);
            chk("reset ins_dout", ins_dout[k], 32'h0);
            chk("reset data_dout", data_dout[k], 32'h0);
            chk("reset mem_en", 32'(mem_en[k]), 32'h0);
        end
        chk("reset busy follows req", 32'(data_busy[2]), 32'h1);
        chk("reset busy idle", 32'(ins_busy[2]), 32'h0);

        // Simultaneous requests straight after reset on the LATENCY=2 instance
        step();
        reset        = 1'b0;
        data_req[2]  = 1'b0;
        ins_addr[0]  = 32'h0000_0100;
        ins_req[0]   = 1'b1;
        data_addr[0] = 32'h2000_0000;
        data_req[0]  = 1'b1;
        sample();
        chk("tie c0 ins_busy", 32'(ins_busy[0]), 32'h1);
        chk("tie c0 data_busy", 32'(data_busy[0]), 32'h1);
        chk("tie c0 mem_en", 32'(mem_en[0]), 32'h0);
        step(); sample();
        chk("tie c1 mem_addr", mem_addr[0], 32'h0000_0100);
        step(); sample();
        chk("tie c2 ins_busy", 32'(ins_busy[0]), 32'h0);
        chk("tie c2 ins_dout", ins_dout[0], 32'h5A5A_0100);
        chk("tie c2 data_busy", 32'(data_busy[0]), 32'h1);
        step();
        ins_addr[0] = 32'h0000_0104;
        sample();
        chk("tie c3 bubble", 32'(mem_en[0]), 32'h0);
        step(); sample();
        chk("tie c4 data wins", mem_addr[0], 32'h2000_0000);
        step(); sample();
        chk("tie c5 data_busy", 32'(data_busy[0]), 32'h0);
        chk("tie c5 data_dout", data_dout[0], 32'h7A5A_0000);
        chk("tie c5 ins_busy", 32'(ins_busy[0]), 32'h1);
        step();
        data_req[0] = 1'b0;
        step(); sample();
        chk("tie c7 mem_addr", mem_addr[0], 32'h0000_0104);
        step(); sample();
        chk("tie c8 ins_dout", ins_dout[0], 32'h5A5A_0104);
        step();
        ins_req[0] = 1'b0;
        step();

        // Single load
        w0 = wcnt[0];
        data_addr[0]  = 32'h1000_0010;
        data_write[0] = 1'b0;
        data_req[0]   = 1'b1;
        sample(); chk("load c0 busy", 32'(data_busy[0]), 32'h1);
        step(); sample(); chk("load c1 busy", 32'(data_busy[0]), 32'h1);
        step(); sample();
        chk("load c2 busy", 32'(data_busy[0]), 32'h0);
        chk("load c2 dout", data_dout[0], 32'hDEAD_BEEF);
        step();
        data_req[0] = 1'b0;
        chk("load no write", 32'(wcnt[0] - w0), 32'h0);
        step();

        // Single store
        w0 = wcnt[0];
        data_addr[0]  = 32'h1000_0004;
        data_din[0]   = 32'h1234_5678;
        data_write[0] = 1'b1;
        data_req[0]   = 1'b1;
        sample(); chk("store c0 we", 32'(mem_we[0]), 32'h0);
        step(); sample(); chk("store c1 we", 32'(mem_we[0]), 32'h0);
        step(); sample();
        chk("store c2 we", 32'(mem_we[0]), 32'h1);
        chk("store c2 addr", mem_addr[0], 32'h1000_0004);
        chk("store c2 din", mem_din[0], 32'h1234_5678);
        step();
        data_req[0]   = 1'b0;
        data_write[0] = 1'b0;
        chk("store one write", 32'(wcnt[0] - w0), 32'h1);
        chk("store memory", rd(0, 32'h1000_0004), 32'h1234_5678);
        step();

        // Reset in the second access cycle of a store
        w0 = wcnt[0];
        data_addr[0]  = 32'h1000_0008;
        data_din[0]   = 32'hCAFE_F00D;
        data_write[0] = 1'b1;
        data_req[0]   = 1'b1;
        step();
        step();
        reset = 1'b1;
        sample();
        chk("abort we", 32'(mem_we[0]), 32'h0);
        chk("abort busy", 32'(data_busy[0]), 32'h1);
        step();
        reset = 1'b0;
        chk("abort no write", 32'(wcnt[0] - w0), 32'h0);
        chk("abort memory", rd(0, 32'h1000_0008), 32'h4A5A_0008);
        got = 0;
        for (int w = 0; w < 10 && got == 0; w++) begin
            sample();
            if (!data_busy[0]) got = 1;
            else step();
        end
        chk("reserve served", got, 1);
        step();
        data_req[0]   = 1'b0;
        data_write[0] = 1'b0;
        chk("reserve one write", 32'(wcnt[0] - w0), 32'h1);
        chk("reserve memory", rd(0, 32'h1000_0008), 32'hCAFE_F00D);
        step();

        // Streaming fetch on the LATENCY=3 instance
        ins_addr[1] = 32'h0000_0200;
        ins_req[1]  = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            got = 0;
            for (int w = 0; w < 10 && got == 0; w++) begin
                sample();
                if (!ins_busy[1]) got = 1;
                else step();
            end
            chk("stream served", got, 1);
            if (i > 0) chk("stream gap", cyc - prev, 4);
            prev = cyc;
            chk("stream fetch data", ins_dout[1], 32'h5A5A_0200 + 32'(4 * i));
            chk("stream fetch addr", mem_addr[1], 32'h0000_0200 + 32'(4 * i));
            step();
            ins_addr[1] = ins_addr[1] + 32'h4;
        end
        ins_req[1] = 1'b0;
        step();

        // Both held on the LATENCY=1 instance: strict alternation, INS first
        ins_addr[2]   = 32'h0000_0300;
        data_addr[2]  = 32'h0000_0400;
        data_write[2] = 1'b0;
        ins_req[2]    = 1'b1;
        data_req[2]   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample();
            chk("alt ins_busy", 32'(ins_busy[2]), (c % 4 == 1) ? 32'h0 : 32'h1);
            chk("alt data_busy", 32'(data_busy[2]), (c % 4 == 3) ? 32'h0 : 32'h1);
            step();
        end
        ins_req[2]  = 1'b0;
        data_req[2] = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
